mux_pipe: RTL

- Parametrised N:1 datapath selector with one registered output stage and a valid/ready handshake.
- A two-entry skid buffer gives full throughput under backpressure.
- Successor to the combinational 16-bit 4:1 operand mux used in the datapath.
- Sits between the register-file/forwarding sources and the ALU operand latch, so the EX stage can stall without losing a selected operand.

---
 rtl/mux_pipe_pkg.sv | 24 ++
 rtl/pipe_skid.sv | 85 ++++++++
 rtl/mux_pipe.sv | 64 ++++++
 3 files changed

// File: rtl/mux_pipe_pkg.sv
// Shared definitions for the operand selector pipeline.
//   DATA_W          : default datapath width
//   sel_width()     : select width for N inputs, ceil(log2(N)) with a floor of 1
//   skid_state_e    : occupancy of the main/skid register pair
package mux_pipe_pkg;

  localparam int DATA_W = 16;

  function automatic int sel_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid.sv
// Two-entry registered pipeline stage (main output register + skid register)
// with a valid/ready handshake and full throughput under backpressure.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_payload/in_valid     : upstream beat
//   in_ready                : registered, high whenever the skid entry is free
//   out_payload/out_valid   : contents of the main register
//   out_ready               : downstream accepts the main register this cycle
module pipe_skid
  import mux_pipe_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] in_payload,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [PW-1:0] out_payload,
  output logic          out_valid,
  input  logic          out_ready
);

  skid_state_e   state_q, state_d;
  logic [PW-1:0] main_q, skid_q;
  logic          in_ready_q;
  logic          accept, drain;
  logic          load_main_in, load_main_skid, load_skid;

  assign accept      = in_valid && in_ready_q;
  assign drain       = out_valid && out_ready;
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_payload = main_q;
  assign in_ready    = in_ready_q;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d      = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a drain can happen
        if (drain) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q <= state_d;
      // registered copy of !skid_valid for the next cycle
      in_ready_q <= (state_d != ST_FULL);
      if (load_main_in)        main_q <= in_payload;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid) skid_q <= in_payload;
    end
  end

endmodule

// File: rtl/mux_pipe.sv
// Registered N:1 operand selector with valid/ready handshake.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data             : NUM_IN flattened inputs, input k at [k*WIDTH +: WIDTH]
//   in_sel              : binary select, captured with in_data on accept
//   in_valid / in_ready : upstream handshake (in_ready registered)
//   out_data            : selected data (0 for an out-of-range select)
//   out_sel             : select that produced out_data
//   out_err             : the beat's select was >= NUM_IN
//   out_valid/out_ready : downstream handshake
module mux_pipe
  import mux_pipe_pkg::*;
#(
  parameter  int WIDTH  = DATA_W,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int PW = WIDTH + SEL_W + 1;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic [PW-1:0]    in_payload, out_payload;

  // Only legal select values match; anything else leaves data at 0 and flags err.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  assign in_payload = {sel_err, in_sel, sel_data};

  pipe_skid #(.PW(PW)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_payload  (in_payload),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_payload (out_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  assign {out_err, out_sel, out_data} = out_payload;

endmodule
